// File: rtl/apb_wdog_pkg.sv
// apb_wdog_pkg: register offsets, CONTROL bit positions, unlock key and
// reset values shared by the watchdog top and its counter sub-module.
package apb_wdog_pkg;

  // Byte offsets within the 4 KiB APB window.
  localparam logic [11:0] OFF_LOAD    = 12'h000;
  localparam logic [11:0] OFF_VALUE   = 12'h004;
  localparam logic [11:0] OFF_CONTROL = 12'h008;
  localparam logic [11:0] OFF_INTCLR  = 12'h00C;
  localparam logic [11:0] OFF_RIS     = 12'h010;
  localparam logic [11:0] OFF_MIS     = 12'h014;
  localparam logic [11:0] OFF_LOCK    = 12'hC00;

  localparam int CTRL_INTEN_BIT = 0;
  localparam int CTRL_RESEN_BIT = 1;

  localparam logic [31:0] UNLOCK_KEY = 32'h1ACC_E551;

  localparam logic [31:0] LOAD_RST    = 32'hFFFF_FFFF;
  localparam logic [31:0] COUNT_RST   = 32'hFFFF_FFFF;
  localparam logic [1:0]  CONTROL_RST = 2'b00;

endpackage

// File: rtl/apb_wdog_counter.sv
// apb_wdog_counter: watchdog down-counter, raw interrupt status and sticky
// reset request. The terminal count (counter == 0 while enabled) is the zero
// event that reloads the counter and escalates RIS -> dogres.
module apb_wdog_counter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        dogclken,
  input  logic        inten,
  input  logic        resen,
  input  logic [31:0] load_val,
  input  logic        load_wr,
  input  logic [31:0] load_wdata,
  input  logic        intclr_wr,
  output logic [31:0] value,
  output logic        ris,
  output logic        dogres
);
  import apb_wdog_pkg::*;

  logic [31:0] count_q, count_d;
  logic        ris_q, ris_d;
  logic        dogres_q, dogres_d;
  logic        zero_evt;

  // Next-state: decrement, reload on zero event or INTCLR, LOAD write wins;
  // a zero event always leaves RIS set, even against a coincident INTCLR.
  always_comb begin
    count_d  = count_q;
    ris_d    = ris_q;
    dogres_d = dogres_q;
    zero_evt = dogclken && inten && (count_q == 32'd0);
    if (dogclken && inten && (count_q != 32'd0)) count_d = count_q - 32'd1;
    if (zero_evt || intclr_wr) count_d = load_val;
    if (load_wr) count_d = load_wdata;
    if (intclr_wr) ris_d = 1'b0;
    if (zero_evt) begin
      ris_d = 1'b1;
      if (ris_q && resen) dogres_d = 1'b1;
    end
  end

  // Counter state registers; dogres only clears through resetn.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q  <= COUNT_RST;
      ris_q    <= 1'b0;
      dogres_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      ris_q    <= ris_d;
      dogres_q <= dogres_d;
    end
  end

  assign value  = count_q;
  assign ris    = ris_q;
  assign dogres = dogres_q;

endmodule

// File: rtl/apb_wdog.sv
// apb_wdog: APB watchdog timer top. Zero-wait-state APB decode, LOAD and
// CONTROL registers, readback mux and registered masked interrupt.
// Optional register lock at 0xC00 is built when APB_WDOG_LOCK_EN is defined.
module apb_wdog (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic        enable,
  input  logic        write,
  input  logic [11:2] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        dogclken,
  output logic        dogint,
  output logic        dogres
);
  import apb_wdog_pkg::*;

  logic [11:0] off;
  logic        wr_acc;
  logic        wr_ok;
  logic        load_wr, ctrl_wr, intclr_wr;
  logic [31:0] load_q, load_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        dogint_q, dogint_d;
  logic [31:0] value;
  logic        ris;

  assign off    = {addr, 2'b00};
  assign wr_acc = sel && enable && write;

`ifdef APB_WDOG_LOCK_EN
  logic lock_q, lock_d;

  // Lock register stays writable while locked; only the key unlocks it.
  always_comb begin
    lock_d = lock_q;
    if (wr_acc && (off == OFF_LOCK)) lock_d = (wdata != UNLOCK_KEY);
  end

  // Lock state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lock_q <= 1'b0;
    else         lock_q <= lock_d;
  end

  assign wr_ok = wr_acc && !lock_q;
`else
  assign wr_ok = wr_acc;
`endif

  assign load_wr   = wr_ok && (off == OFF_LOAD);
  assign ctrl_wr   = wr_ok && (off == OFF_CONTROL);
  assign intclr_wr = wr_ok && (off == OFF_INTCLR);

  // Next-state for LOAD, CONTROL and the masked interrupt flop.
  always_comb begin
    load_d   = load_q;
    ctrl_d   = ctrl_q;
    dogint_d = ris && ctrl_q[CTRL_INTEN_BIT];
    if (load_wr) load_d = wdata;
    if (ctrl_wr) ctrl_d = {wdata[CTRL_RESEN_BIT], wdata[CTRL_INTEN_BIT]};
  end

  // Register file state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      load_q   <= LOAD_RST;
      ctrl_q   <= CONTROL_RST;
      dogint_q <= 1'b0;
    end else begin
      load_q   <= load_d;
      ctrl_q   <= ctrl_d;
      dogint_q <= dogint_d;
    end
  end

  apb_wdog_counter u_counter (
    .clk        (clk),
    .resetn     (resetn),
    .dogclken   (dogclken),
    .inten      (ctrl_q[CTRL_INTEN_BIT]),
    .resen      (ctrl_q[CTRL_RESEN_BIT]),
    .load_val   (load_q),
    .load_wr    (load_wr),
    .load_wdata (wdata),
    .intclr_wr  (intclr_wr),
    .value      (value),
    .ris        (ris),
    .dogres     (dogres)
  );

  // Read mux: driven whenever a read is selected, zero for WO/unmapped.
  always_comb begin
    rdata = 32'd0;
    if (sel && !write) begin
      case (off)
        OFF_LOAD:    rdata = load_q;
        OFF_VALUE:   rdata = value;
        OFF_CONTROL: rdata = {30'd0, ctrl_q};
        OFF_RIS:     rdata = {31'd0, ris};
        OFF_MIS:     rdata = {31'd0, ris && ctrl_q[CTRL_INTEN_BIT]};
`ifdef APB_WDOG_LOCK_EN
        OFF_LOCK:    rdata = {31'd0, lock_q};
`endif
        default:     rdata = 32'd0;
      endcase
    end
  end

  assign dogint = dogint_q;

endmodule

// File: tb/tb_apb_wdog.sv
// tb_apb_wdog: scoreboard bench for apb_wdog. Stimulus pushes expected
// responses; a monitor pops and compares on every read access phase and on
// every output probe strobe.
module tb_apb_wdog;
  import apb_wdog_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, sel, enable, write, dogclken, probe;
  logic [11:2] addr;
  logic [31:0] wdata, rdata;
  logic        dogint, dogres;

  apb_wdog dut (
    .clk      (clk),
    .resetn   (resetn),
    .sel      (sel),
    .enable   (enable),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .dogclken (dogclken),
    .dogint   (dogint),
    .dogres   (dogres)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          is_read;
    logic [31:0] exp_data;
    logic        exp_int;
    logic        exp_res;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(negedge clk) begin
    exp_t e;
    if ((sel && enable && !write) || probe) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underrun at %0t: no expected entry", $time);
      end else begin
        e = sb.pop_front();
        if (e.is_read) begin
          n_checks++;
          if (rdata !== e.exp_data) begin
            n_fail++;
            $display("FAIL %s: rdata=%h expected=%h", e.name, rdata, e.exp_data);
          end
        end else begin
          n_checks++;
          if (dogint !== e.exp_int) begin
            n_fail++;
            $display("FAIL %s: dogint=%b expected=%b", e.name, dogint, e.exp_int);
          end
          n_checks++;
          if (dogres !== e.exp_res) begin
            n_fail++;
            $display("FAIL %s: dogres=%b expected=%b", e.name, dogres, e.exp_res);
          end
        end
      end
    end
  end

  task automatic apb_write(input logic [11:0] o, input logic [31:0] d);
    sel = 1'b1; write = 1'b1; enable = 1'b0; addr = o[11:2]; wdata = d;
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 sel = 1'b0; enable = 1'b0; write = 1'b0;
  endtask

  // Write whose access edge coincides with an enabled count cycle.
  task automatic apb_write_en(input logic [11:0] o, input logic [31:0] d);
    sel = 1'b1; write = 1'b1; enable = 1'b0; addr = o[11:2]; wdata = d;
    @(posedge clk); #1 enable = 1'b1; dogclken = 1'b1;
    @(posedge clk); #1 sel = 1'b0; enable = 1'b0; write = 1'b0; dogclken = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] o, input logic [31:0] exp, input string name);
    sb.push_back('{name, 1'b1, exp, 1'b0, 1'b0});
    sel = 1'b1; write = 1'b0; enable = 1'b0; addr = o[11:2];
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 sel = 1'b0; enable = 1'b0;
  endtask

  task automatic probe_out(input logic ei, input logic er, input string name);
    sb.push_back('{name, 1'b0, 32'd0, ei, er});
    probe = 1'b1;
    @(posedge clk); #1 probe = 1'b0;
  endtask

  task automatic run_en(input int n);
    dogclken = 1'b1;
    repeat (n) @(posedge clk);
    #1 dogclken = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; sel = 1'b0; enable = 1'b0; write = 1'b0;
    dogclken = 1'b0; probe = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    idle(1);

    // Reset state
    probe_out(1'b0, 1'b0, "rst_outputs");
    apb_read(OFF_LOAD,    32'hFFFF_FFFF, "rst_load");
    apb_read(OFF_VALUE,   32'hFFFF_FFFF, "rst_value");
    apb_read(OFF_CONTROL, 32'h0, "rst_control");
    apb_read(OFF_RIS,     32'h0, "rst_ris");
    apb_read(OFF_MIS,     32'h0, "rst_mis");
    apb_read(OFF_INTCLR,  32'h0, "wo_intclr_reads0");
    apb_read(12'h018,     32'h0, "unmapped_reads0");
    apb_read(OFF_LOCK,    32'h0, "lock_rst");

    // LOAD=3, INTEN: RIS on 4th enabled cycle, dogint one cycle later
    apb_write(OFF_LOAD, 32'd3);
    apb_write(OFF_CONTROL, 32'h1);
    apb_read(OFF_VALUE,   32'd3, "value_after_load");
    apb_read(OFF_CONTROL, 32'h1, "control_inten");
    run_en(3);
    apb_read(OFF_VALUE, 32'd0, "value_at_zero");
    apb_read(OFF_RIS,   32'd0, "ris_before_zero");
    run_en(1);
    probe_out(1'b0, 1'b0, "dogint_lag");
    probe_out(1'b1, 1'b0, "dogint_set");
    apb_read(OFF_RIS,   32'd1, "ris_set");
    apb_read(OFF_MIS,   32'd1, "mis_set");
    apb_read(OFF_VALUE, 32'd3, "value_reload");

    // RESEN: second zero event (8th enabled cycle) raises sticky dogres
    apb_write(OFF_CONTROL, 32'h3);
    run_en(3);
    probe_out(1'b1, 1'b0, "dogres_not_yet");
    run_en(1);
    probe_out(1'b1, 1'b1, "dogres_set");
    apb_read(OFF_RIS,   32'd1, "ris_held");
    apb_read(OFF_VALUE, 32'd3, "value_reload2");
    run_en(10);
    apb_write(OFF_INTCLR, 32'h0);
    apb_read(OFF_RIS,   32'd0, "intclr_clears_ris");
    apb_read(OFF_VALUE, 32'd3, "intclr_reload");
    probe_out(1'b0, 1'b1, "dogres_sticky");

    // Reset mid-count
    apb_write(OFF_CONTROL, 32'h1);
    dogclken = 1'b1;
    idle(3);
    resetn = 1'b0;
    probe_out(1'b0, 1'b0, "rst_mid_outputs");
    apb_read(OFF_VALUE,   32'hFFFF_FFFF, "rst_mid_value");
    apb_read(OFF_CONTROL, 32'h0, "rst_mid_control");
    resetn = 1'b1;
    idle(4);
    apb_read(OFF_VALUE, 32'hFFFF_FFFF, "no_count_after_rst");
    apb_read(OFF_RIS,   32'h0, "ris_after_rst");
    dogclken = 1'b0;

    // dogclken toggling: decrement only on enabled cycles
    apb_write(OFF_LOAD, 32'd5);
    apb_write(OFF_CONTROL, 32'h1);
    apb_read(OFF_VALUE, 32'd5, "toggle_value_0");
    for (int i = 1; i <= 4; i++) begin
      run_en(1);
      idle(1);
      apb_read(OFF_VALUE, 32'd5 - 32'(i), $sformatf("toggle_value_%0d", i));
    end

    // INTCLR coincident with zero event
    apb_write(OFF_LOAD, 32'd2);
    run_en(2);
    apb_write_en(OFF_INTCLR, 32'h0);
    apb_read(OFF_RIS,   32'd1, "intclr_zero_ris");
    apb_read(OFF_VALUE, 32'd2, "intclr_zero_value");
    apb_write(OFF_INTCLR, 32'h0);
    apb_read(OFF_RIS, 32'd0, "intclr_plain");

    // LOAD write coincident with zero event
    run_en(2);
    apb_write_en(OFF_LOAD, 32'd7);
    apb_read(OFF_VALUE, 32'd7, "load_zero_value");
    apb_read(OFF_RIS,   32'd1, "load_zero_ris");
    apb_read(OFF_LOAD,  32'd7, "load_zero_load");

    // Read-only register ignores writes
    apb_write(OFF_VALUE, 32'h1234);
    apb_read(OFF_VALUE, 32'd7, "ro_value");

`ifdef APB_WDOG_LOCK_EN
    apb_write(OFF_LOCK, 32'h0);
    apb_read(OFF_LOCK, 32'd1, "lock_set");
    apb_write(OFF_LOAD, 32'h10);
    apb_read(OFF_LOAD, 32'd7, "locked_load");
    apb_write(OFF_CONTROL, 32'h0);
    apb_read(OFF_CONTROL, 32'h1, "locked_control");
    apb_write(OFF_LOCK, UNLOCK_KEY);
    apb_read(OFF_LOCK, 32'd0, "lock_cleared");
    apb_write(OFF_LOAD, 32'h10);
    apb_read(OFF_LOAD, 32'h10, "unlocked_load");
`else
    apb_write(OFF_LOCK, 32'h0);
    apb_read(OFF_LOCK, 32'd0, "lock_unmapped");
    apb_write(OFF_LOAD, 32'h10);
    apb_read(OFF_LOAD, 32'h10, "load_always_writable");
`endif

    idle(2);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_wdog.md
APB_WDOG -- requirements
Module: apb_wdog

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port: resetn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: sel  input  1  APB select.
REQ-004 SHALL have port: enable  input  1  APB enable; access phase = sel && enable.
REQ-005 SHALL have port: write  input  1  1 = write, 0 = read.
REQ-006 SHALL have port: addr  input  [11:2]  word address.
REQ-007 SHALL have port: wdata  input  32  write data.
REQ-008 SHALL have port: rdata  output  32  read data.
REQ-009 SHALL have port: dogclken  input  1  count-enable qualifier, same clock domain.
REQ-010 SHALL have port: dogint  output  1  masked interrupt, registered.
REQ-011 SHALL have port: dogres  output  1  watchdog reset request, registered, sticky.

Function
REQ-012 SHALL accept accesses with zero wait states; no ready output.
REQ-013 SHALL update registers at the clock edge where sel && enable && write.
REQ-014 SHALL use this register map:
- 0x000 LOAD (RW, 32b)
- 0x004 VALUE (RO)
- 0x008 CONTROL (RW; bit0 INTEN, bit1 RESEN)
- 0x00C INTCLR (WO)
- 0x010 RIS (RO, bit0)
- 0x014 MIS (RO, bit0 = RIS & INTEN)
REQ-015 SHALL drive rdata combinationally when sel && !write; SHALL drive 0 otherwise and for unmapped/WO addresses; rdata SHALL never be X.
REQ-016 SHALL load counter := wdata in the cycle after a LOAD write.
REQ-017 SHALL decrement counter by 1 on each cycle with dogclken=1, INTEN=1, counter != 0.
REQ-018 Zero event (dogclken=1, INTEN=1, counter == 0) SHALL:
- reload counter from LOAD;
- if RIS=1 and RESEN=1, set dogres=1;
- otherwise set RIS=1.
REQ-019 SHALL hold counter and RIS while INTEN=0; dogint SHALL be 0 while INTEN=0.
REQ-020 Any write to INTCLR SHALL clear RIS and reload counter from LOAD.
REQ-021 LOAD write coincident with zero event: counter SHALL take wdata; RIS/dogres update SHALL still occur.
REQ-022 INTCLR write coincident with zero event: RIS SHALL end at 1 and counter SHALL equal LOAD.
REQ-023 SHALL keep dogres at 1 once set, until resetn.
REQ-024 SHALL register dogint = RIS & INTEN, one cycle after the RIS/INTEN change.

Reset
REQ-025 While resetn=0 SHALL force:
- LOAD = 0xFFFFFFFF, counter = 0xFFFFFFFF;
- CONTROL = 0, RIS = 0;
- dogint = 0, dogres = 0, lock = 0.
REQ-026 Reset asserted mid-count SHALL abort immediately; counting SHALL resume only after INTEN is rewritten.

Configuration
REQ-027 With APB_WDOG_LOCK_EN defined, SHALL implement LOCK at 0xC00:
- writing 0x1ACCE551 clears lock; any other value sets lock;
- read returns {31'b0, lock};
- while lock=1, writes to all other registers SHALL be ignored.
REQ-028 Without APB_WDOG_LOCK_EN, 0xC00 SHALL be unmapped (reads 0, writes ignored); all registers always writable.

Structure
REQ-029 Package apb_wdog_pkg SHALL hold:
- register offset constants;
- CONTROL bit positions;
- the unlock key constant;
- reset-value constants.
REQ-030 SHALL instantiate one sub-module, apb_wdog_counter: counter, RIS, dogres, zero-event logic; APB decode and readback stay in apb_wdog.

Verification
REQ-031 LOAD=3, CONTROL=0x1, dogclken=1 continuous -> RIS=1 after the 4th enabled cycle; dogint=1 one cycle later; VALUE reads 3.
REQ-032 Continue REQ-031 setup with CONTROL=0x3 and no INTCLR -> dogres=1 on the second zero event (8th enabled cycle); dogres stays 1 until resetn.
REQ-033 LOAD=5, toggle dogclken every other cycle -> VALUE decrements only on dogclken cycles (5,4,3...).
REQ-034 INTCLR write in the same cycle as a zero event -> RIS reads 1 and VALUE reads LOAD.
REQ-035 With APB_WDOG_LOCK_EN: write LOCK=0x0, then LOAD=0x10 -> LOAD unchanged. Write LOCK=0x1ACCE551, then LOAD=0x10 -> LOAD=0x10.
REQ-036 resetn pulsed low mid-count -> all outputs 0, VALUE = 0xFFFFFFFF, rdata never X on reads.
